// File: rtl/game_pkg.sv
// Shared definitions for the tic-tac-toe style board logic.
//   PLAYER_X / PLAYER_O : encoding of the player-to-move flag
//   state_e             : move decoder FSM states (PLAY accepts moves, DONE frozen)
//   GAME_NUM_CELLS      : default board size
package game_pkg;

    localparam logic PLAYER_X = 1'b0;
    localparam logic PLAYER_O = 1'b1;

    localparam int GAME_NUM_CELLS = 9;

    typedef enum logic [0:0] {
        ST_PLAY = 1'b0,
        ST_DONE = 1'b1
    } state_e;

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder with range flag.
//   sel      : binary cell index
//   onehot   : bit sel set; all-zero when sel >= NUM_CELLS
//   in_range : 1 when sel < NUM_CELLS
module onehot_dec #(
    parameter int NUM_CELLS = 9,
    parameter int SEL_W     = 4
) (
    input  logic [SEL_W-1:0]     sel,
    output logic [NUM_CELLS-1:0] onehot,
    output logic                 in_range
);

    // Compare against every legal index; an out-of-range index matches none.
    always_comb begin
        onehot = {NUM_CELLS{1'b0}};
        for (int i = 0; i < NUM_CELLS; i++) begin
            onehot[i] = (sel == SEL_W'(i));
        end
    end

    // Exactly one bit is set iff the index addresses a real cell.
    assign in_range = |onehot;

endmodule

// File: rtl/move_decoder.sv
// Registered cell-select decoder for the game board.
//   clk, rst  : clock, synchronous active-high reset
//   sel       : requested cell index, qualified by sel_valid
//   lock      : game over; freezes the board (state -> DONE)
//   clear     : synchronous new-game request, same effect as reset
//   en        : one-cycle one-hot write enable for the accepted cell
//   player    : player to move (0 = X, 1 = O)
//   occupied  : cells accepted so far
//   move_cnt  : accepted moves since reset/clear (saturates at NUM_CELLS)
//   accept    : one-cycle pulse with en
//   reject    : one-cycle pulse for a refused request
//   full      : every cell occupied
// All outputs are registered; a request in cycle N is answered in cycle N+1.
module move_decoder
    import game_pkg::*;
#(
    parameter int NUM_CELLS = GAME_NUM_CELLS,
    parameter int SEL_W     = 4,
    parameter int CNT_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 sel_valid,
    input  logic                 lock,
    input  logic                 clear,
    output logic [NUM_CELLS-1:0] en,
    output logic                 player,
    output logic [NUM_CELLS-1:0] occupied,
    output logic [CNT_W-1:0]     move_cnt,
    output logic                 accept,
    output logic                 reject,
    output logic                 full
);

    state_e                 state_r;
    state_e                 state_next_s;
    logic [NUM_CELLS-1:0]   onehot_s;
    logic                   in_range_s;
    logic                   legal_s;
    logic                   accept_s;
    logic                   reject_s;
    logic [NUM_CELLS-1:0]   occ_after_s;

    logic [NUM_CELLS-1:0]   en_r;
    logic                   player_r;
    logic [NUM_CELLS-1:0]   occupied_r;
    logic [CNT_W-1:0]       move_cnt_r;
    logic                   accept_r;
    logic                   reject_r;
    logic                   full_r;

    onehot_dec #(
        .NUM_CELLS (NUM_CELLS),
        .SEL_W     (SEL_W)
    ) u_dec (
        .sel      (sel),
        .onehot   (onehot_s),
        .in_range (in_range_s)
    );

    // Occupancy as it would look if the current request were accepted.
    assign occ_after_s = occupied_r | onehot_s;

    // An occupied target shows up as an overlap with the one-hot vector.
    assign legal_s = (state_r == ST_PLAY) && !lock && in_range_s
                     && !(|(occupied_r & onehot_s));

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_PLAY;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state: clear beats lock, and the move that fills the board ends the game.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_PLAY: begin
                if (clear) begin
                    state_next_s = ST_PLAY;
                end else if (lock) begin
                    state_next_s = ST_DONE;
                end else if (accept_s && (&occ_after_s)) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_PLAY;
                end
            end
            ST_DONE: begin
                if (clear) begin
                    state_next_s = ST_PLAY;
                end else begin
                    state_next_s = ST_DONE;
                end
            end
            default: begin
                state_next_s = ST_PLAY;
            end
        endcase
    end

    // FSM outputs: classify the request; a request coincident with clear is dropped.
    always_comb begin
        accept_s = 1'b0;
        reject_s = 1'b0;
        if (clear) begin
            accept_s = 1'b0;
            reject_s = 1'b0;
        end else if (sel_valid) begin
            accept_s = legal_s;
            reject_s = !legal_s;
        end else begin
            accept_s = 1'b0;
            reject_s = 1'b0;
        end
    end

    // Board bookkeeping and output pulse registers.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            en_r       <= {NUM_CELLS{1'b0}};
            player_r   <= PLAYER_X;
            occupied_r <= {NUM_CELLS{1'b0}};
            move_cnt_r <= {CNT_W{1'b0}};
            accept_r   <= 1'b0;
            reject_r   <= 1'b0;
            full_r     <= 1'b0;
        end else begin
            accept_r <= accept_s;
            reject_r <= reject_s;
            if (accept_s) begin
                en_r       <= onehot_s;
                occupied_r <= occ_after_s;
                full_r     <= &occ_after_s;
                player_r   <= (player_r == PLAYER_X) ? PLAYER_O : PLAYER_X;
                if (move_cnt_r != CNT_W'(NUM_CELLS)) begin
                    move_cnt_r <= move_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    move_cnt_r <= move_cnt_r;
                end
            end else begin
                en_r <= {NUM_CELLS{1'b0}};
            end
        end
    end

    assign en       = en_r;
    assign player   = player_r;
    assign occupied = occupied_r;
    assign move_cnt = move_cnt_r;
    assign accept   = accept_r;
    assign reject   = reject_r;
    assign full     = full_r;

endmodule
